// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-digit time slots with dead-time,
// frame-synchronous double-buffered value, leading-zero and invalid-code blanking.
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int DEAD_CYC   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic                    i_lz_en,
  input  logic                    i_blank,
  output logic [3:0]              o_bcd,
  output logic [NUM_DIGITS-1:0]   o_digit_en,
  output logic                    o_frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pend_valid;

  logic                    slot_end;
  logic                    boundary;
  logic [3:0]              cur;
  logic                    seen;
  logic                    keep;
  logic                    valid;
  logic                    show;
  logic [3:0]              bcd_nx;
  logic [NUM_DIGITS-1:0]   en_nx;

  always_comb begin
    slot_end = (cnt == CNT_MAX);
    boundary = slot_end && (idx == IDX_MAX);
    cur      = '0;
    keep     = 1'b0;
    seen     = 1'b0;
    // Walk from the most significant digit down so 'seen' marks digits at or
    // below the highest nonzero one; digit 0 is always kept.
    for (int unsigned j = NUM_DIGITS; j > 0; j--) begin
      seen = seen | (|active[4*(j-1) +: 4]);
      if (idx == IW'(j - 1)) begin
        cur  = active[4*(j-1) +: 4];
        keep = seen || (j == 1);
      end
    end
    valid  = (cur <= 4'd9);
    show   = valid && (!i_lz_en || keep) && !i_blank && (cnt >= CNT_DEAD);
    bcd_nx = valid ? cur : 4'd0;
    en_nx  = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      en_nx[k] = show && (idx == IW'(k));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt          <= '0;
      idx          <= '0;
      active       <= '0;
      pending      <= '0;
      pend_valid   <= 1'b0;
      o_bcd        <= '0;
      o_digit_en   <= '0;
      o_frame_done <= 1'b0;
    end else begin
      cnt          <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
      o_frame_done <= boundary;
      o_bcd        <= bcd_nx;
      o_digit_en   <= en_nx;
      // A load on the boundary bypasses the pending buffer entirely.
      if (i_load && boundary) begin
        active     <= i_value;
        pend_valid <= 1'b0;
      end else if (i_load) begin
        pending    <= i_value;
        pend_valid <= 1'b1;
      end else if (boundary && pend_valid) begin
        active     <= pending;
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with NUM_DIGITS=4, PRESCALE=4, DEAD_CYC=1:
// a frame is 16 cycles, each slot one dead cycle followed by three lit cycles.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        lz;
  logic        blank;
  logic [15:0] value;
  logic [3:0]  bcd;
  logic [3:0]  en;
  logic        fd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4), .DEAD_CYC(1)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_value     (value),
    .i_load      (load),
    .i_lz_en     (lz),
    .i_blank     (blank),
    .o_bcd       (bcd),
    .o_digit_en  (en),
    .o_frame_done(fd)
  );

  // ebcd/een hold the expected o_bcd and lit-cycle o_digit_en per slot, slot s at [4s+3:4s]
  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [15:0] ebcd;
    logic [15:0] een;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Checks one whole frame; j=0 is the dead cycle of slot 0. Optional loads are
  // raised right after sampling cycle la/lb (lb=14 lands on the boundary edge).
  task automatic frame(input string tag, input logic [15:0] ebcd, input logic [15:0] een,
                       input bit nowait, input int la, input logic [15:0] va,
                       input int lb, input logic [15:0] vb);
    int n;
    logic [3:0] exp_en;
    n = 0;
    if (!nowait) begin
      while (fd !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk({tag, " sync"}, {15'h0, fd}, 16'h0001);
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      exp_en = (j % 4 == 0) ? 4'h0 : een[4*(j/4) +: 4];
      chk($sformatf("%s bcd j%0d", tag, j), {12'h0, bcd}, {12'h0, ebcd[4*(j/4) +: 4]});
      chk($sformatf("%s en j%0d", tag, j), {12'h0, en}, {12'h0, exp_en});
      chk($sformatf("%s fd j%0d", tag, j), {15'h0, fd}, (j == 15) ? 16'h0001 : 16'h0000);
      load = 1'b0;
      if (j == la) begin
        value = va;
        load  = 1'b1;
      end
      if (j == lb) begin
        value = vb;
        load  = 1'b1;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{value: 16'h1234, lz: 1'b0, ebcd: 16'h1234, een: 16'h8421};
    vecs[1] = '{value: 16'h0070, lz: 1'b1, ebcd: 16'h0070, een: 16'h0021};
    vecs[2] = '{value: 16'h0000, lz: 1'b1, ebcd: 16'h0000, een: 16'h0001};
    vecs[3] = '{value: 16'h1A23, lz: 1'b0, ebcd: 16'h1023, een: 16'h8021};
    vecs[4] = '{value: 16'h0300, lz: 1'b1, ebcd: 16'h0300, een: 16'h0421};
    vecs[5] = '{value: 16'h0070, lz: 1'b0, ebcd: 16'h0070, een: 16'h8421};

    // load during reset must be ignored
    rst   = 1'b1;
    load  = 1'b1;
    value = 16'hFFFF;
    lz    = 1'b0;
    blank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst bcd", {12'h0, bcd}, 16'h0000);
      chk("rst en", {12'h0, en}, 16'h0000);
      chk("rst fd", {15'h0, fd}, 16'h0000);
    end
    rst  = 1'b0;
    load = 1'b0;
    frame("post_rst", 16'h0000, 16'h8421, 1'b1, -1, '0, -1, '0);

    for (int i = 0; i < 6; i++) begin
      lz = vecs[i].lz;
      do_load(vecs[i].value);
      frame($sformatf("vec%0d", i), vecs[i].ebcd, vecs[i].een, 1'b0, -1, '0, -1, '0);
    end

    // last write wins: 5555 then 6666 inside one frame, display holds 1234 meanwhile
    lz = 1'b0;
    do_load(16'h1234);
    frame("lww_pre", 16'h1234, 16'h8421, 1'b0, -1, '0, -1, '0);
    frame("lww_hold", 16'h1234, 16'h8421, 1'b0, 3, 16'h5555, 7, 16'h6666);
    frame("lww_new", 16'h6666, 16'h8421, 1'b0, -1, '0, -1, '0);
    frame("lww_again", 16'h6666, 16'h8421, 1'b0, -1, '0, -1, '0);

    // pending 4321, then 8765 loaded on the boundary edge: 8765 wins, pending cleared
    frame("bnd_hold", 16'h6666, 16'h8421, 1'b0, 4, 16'h4321, 14, 16'h8765);
    frame("bnd_new", 16'h8765, 16'h8421, 1'b0, -1, '0, -1, '0);
    frame("bnd_again", 16'h8765, 16'h8421, 1'b0, -1, '0, -1, '0);

    blank = 1'b1;
    frame("blank", 16'h8765, 16'h0000, 1'b0, -1, '0, -1, '0);
    blank = 1'b0;
    frame("unblank", 16'h8765, 16'h8421, 1'b0, -1, '0, -1, '0);

    // reset mid-frame with 2222 pending
    repeat (3) @(negedge clk);
    do_load(16'h2222);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mrst bcd", {12'h0, bcd}, 16'h0000);
      chk("mrst en", {12'h0, en}, 16'h0000);
      chk("mrst fd", {15'h0, fd}, 16'h0000);
    end
    rst = 1'b0;
    frame("mrst_restart", 16'h0000, 16'h8421, 1'b1, -1, '0, -1, '0);
    frame("mrst_nopend", 16'h0000, 16'h8421, 1'b0, -1, '0, -1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed 7-segment digits (legal range 2..8).
REQ-002 The block SHALL have parameter PRESCALE, default 50000, giving the clock cycles each digit slot lasts (legal range ≥ 4).
REQ-003 The block SHALL have parameter DEAD_CYC, default 2, giving the all-off cycles at the start of each slot (legal range 1..PRESCALE-2).
REQ-004 Port i_clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 Port i_rst, input, 1 bit: synchronous active-high reset, sampled on i_clk.
REQ-006 Port i_value, input, 4*NUM_DIGITS bits: BCD digits, with digit k at bits [4k+3:4k] and digit 0 the least significant.
REQ-007 Port i_load, input, 1 bit: a 1-cycle strobe that captures i_value as the pending frame.
REQ-008 Port i_lz_en, input, 1 bit: enables leading-zero suppression.
REQ-009 Port i_blank, input, 1 bit: forces all digit enables off.
REQ-010 Port o_bcd, output, 4 bits: BCD code for the external BCD-to-7-segment decoder.
REQ-011 Port o_digit_en, output, NUM_DIGITS bits: one-hot active-high digit select.
REQ-012 Port o_frame_done, output, 1 bit: 1-cycle pulse when the last digit slot ends.

Function
REQ-013 A prescale counter SHALL count 0..PRESCALE-1 and wrap; the terminal count (PRESCALE-1) is the slot end.
REQ-014 A digit index SHALL advance by 1 at each slot end, wrapping from NUM_DIGITS-1 to 0; the order is 0,1,...,NUM_DIGITS-1.
REQ-015 The wrap of the index from NUM_DIGITS-1 to 0 SHALL be the frame boundary; o_frame_done SHALL be 1 in the cycle after that slot end.
REQ-016 On i_load, i_value SHALL be stored in the pending register and pending_valid SHALL be set to 1.
REQ-017 At a frame boundary with pending_valid=1, the active register SHALL take the pending value and pending_valid SHALL clear, so frames never tear.
REQ-018 If i_load coincides with a frame boundary, the active register SHALL take i_value directly and pending_valid SHALL be left at 0.
REQ-019 Two or more i_load strobes within one frame SHALL follow last-write-wins.
REQ-020 Outputs SHALL be registered: o_bcd and o_digit_en reflect the counter and index state one cycle later.
REQ-021 o_digit_en SHALL be all-zero while counter < DEAD_CYC (anti-ghosting); otherwise it SHALL have exactly bit[index] set, subject to REQ-022 to REQ-024.
REQ-022 An active digit value greater than 9 SHALL force o_bcd=0 and that digit's enable off, because the downstream decoder has no output for codes above 9.
REQ-023 With i_lz_en=1, every digit above the most significant nonzero digit SHALL be disabled; digit 0 SHALL always remain enabled, so the value 0 displays as "0".
REQ-024 i_blank=1 SHALL force o_digit_en=0 from the next cycle, while scanning, loading and o_frame_done continue unaffected.
REQ-025 o_bcd SHALL present the active digit[index] value whenever that digit is valid, including during dead cycles.

Reset
REQ-026 While i_rst=1: the counter, index, active register, pending register, pending_valid, o_bcd, o_digit_en and o_frame_done SHALL all be 0.
REQ-027 Reset asserted mid-frame SHALL discard any pending value.
REQ-028 Scanning SHALL restart at digit 0 with counter=0 on the first cycle after i_rst deasserts.
REQ-029 i_load in a cycle where i_rst=1 SHALL be ignored.

Verification
REQ-030 The bench SHALL cover the following scenarios, all with NUM_DIGITS=4, PRESCALE=4 and DEAD_CYC=1:
- Reset → i_load i_value=16'h1234, i_lz_en=0 → after the next frame boundary, digits in order show o_bcd 4,3,2,1; each slot gives 1 dead cycle then 3 cycles with o_digit_en=0001, 0010, 0100, 1000; o_frame_done pulses every 16 cycles.
- i_value=16'h0070, i_lz_en=1 → digits 3 and 2 never enabled, digits 1 (7) and 0 (0) enabled; then i_value=16'h0000 → only digit 0 enabled, showing 0.
- i_load 16'h5555 mid-frame, followed by 16'h6666 in the same frame → display unchanged until the boundary, then shows 6666, with 5555 never displayed.
- i_load coinciding with the boundary cycle → the new value appears in the very next frame and pending_valid=0.
- Active value 16'h1A23 → digit 2 slot has o_digit_en=0000 and o_bcd=0, while the other digits display normally.
- i_blank held for 1 frame → o_digit_en=0 throughout while o_frame_done still pulses; i_rst mid-frame with a pending load → all outputs 0, pending lost, restart at digit 0.
